// File: rtl/bus_ctrl_pkg.sv
// Shared types and constants for the bus grant controller.
// Optional feature macro: BUS_GRANT_TIMEOUT_EN (hold-limit revocation).
package bus_ctrl_pkg;

    localparam int unsigned NUM_REQ          = 4;
    localparam int unsigned MAX_HOLD_DEFAULT = 16;
    localparam int unsigned HOLD_W           = 8;

    typedef logic [1:0]         req_idx_t;
    typedef logic [NUM_REQ-1:0] req_vec_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } bus_state_e;

    // One-hot grant vector for a requester index.
    function automatic req_vec_t onehot(input req_idx_t idx);
        req_vec_t v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/bus_grant_ctrl_if.sv
// Requester-side bus signals of the grant controller, plus FSM debug taps.
// Optional feature macro: BUS_GRANT_TIMEOUT_EN (affects timeout only).
//
// Handshake: req[i] is a level request held high for as long as requester i
// wants the bus; gnt[i] (registered, one-hot or zero) is the ownership. The
// owner keeps the bus until it drops req[i]; the cycle after that drop is
// seen, gnt is zero for one turnaround cycle.
interface bus_grant_ctrl_if;
    import bus_ctrl_pkg::*;

    req_vec_t            req;
    req_vec_t            gnt;
    req_idx_t            gnt_id;
    logic                busy;
    logic                timeout;
    bus_state_e          state;
    logic [HOLD_W-1:0]   hold_cnt;

    modport master (output req,
                    input  gnt, gnt_id, busy, timeout, state, hold_cnt);

    modport slave  (input  req,
                    output gnt, gnt_id, busy, timeout, state, hold_cnt);

endinterface

// File: rtl/bus_grant_ctrl_rr_pick.sv
// Round-robin selection: first asserted requester searching upward from
// (last_owner + 1) mod NUM_REQ. Purely combinational.
module rr_pick
    import bus_ctrl_pkg::*;
(
    input  req_vec_t req,
    input  req_idx_t last_owner,
    output logic     valid,
    output req_idx_t index
);

    req_idx_t cand;

    // Scan offsets 1..NUM_REQ; offset NUM_REQ wraps back to last_owner itself.
    always_comb begin
        valid = 1'b0;
        index = last_owner;
        cand  = last_owner;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = last_owner + req_idx_t'(k);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/bus_grant_ctrl.sv
// Round-robin shared-bus grant controller with one-cycle turnaround.
// Optional feature macro: BUS_GRANT_TIMEOUT_EN -- revoke an ownership after
// MAX_HOLD consecutive grant cycles (legal MAX_HOLD range 2..255).
module bus_grant_ctrl
    import bus_ctrl_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    bus_grant_ctrl_if.slave  bus
);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    bus_state_e        state_q, state_d;
    req_vec_t          gnt_q, gnt_d;
    req_idx_t          owner_q, owner_d;
    req_idx_t          last_owner_q, last_owner_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
`ifdef BUS_GRANT_TIMEOUT_EN
    logic              timeout_q, timeout_d;
`endif

    logic     pick_valid;
    req_idx_t pick_idx;
    req_idx_t pick_base;

    // During turnaround the released owner is already the lowest-priority
    // reference, even though last_owner_q only takes it at the end of RELEASE.
    assign pick_base = (state_q == ST_RELEASE) ? owner_q : last_owner_q;

    rr_pick u_rr_pick (
        .req        (bus.req),
        .last_owner (pick_base),
        .valid      (pick_valid),
        .index      (pick_idx)
    );

    // State register; every output flop clears asynchronously on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            owner_q      <= '0;
            last_owner_q <= req_idx_t'(NUM_REQ - 1);
            hold_q       <= '0;
`ifdef BUS_GRANT_TIMEOUT_EN
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            hold_q       <= hold_d;
`ifdef BUS_GRANT_TIMEOUT_EN
            timeout_q    <= timeout_d;
`endif
        end
    end

    // Next-state logic. RELEASE is the single gnt=0 turnaround cycle; at its
    // end it records the released owner and, if anyone is requesting,
    // arbitrates straight into the next GRANT (otherwise it settles in IDLE),
    // so back-to-back owners are separated by exactly one idle bus cycle.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        hold_d       = hold_q;
`ifdef BUS_GRANT_TIMEOUT_EN
        timeout_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE, ST_RELEASE: begin
                if (state_q == ST_RELEASE) begin
                    last_owner_d = owner_q;
                end
                if (pick_valid) begin
                    state_d = ST_GRANT;
                    gnt_d   = onehot(pick_idx);
                    owner_d = pick_idx;
                    hold_d  = HOLD_W'(1);
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    hold_d  = '0;
                end
            end
            ST_GRANT: begin
                if (!bus.req[owner_q]) begin
                    state_d = ST_RELEASE;
                    gnt_d   = '0;
                    hold_d  = '0;
                end
`ifdef BUS_GRANT_TIMEOUT_EN
                else if (hold_q == HOLD_MAX) begin
                    state_d   = ST_RELEASE;
                    gnt_d     = '0;
                    hold_d    = '0;
                    timeout_d = 1'b1;
                end
`endif
                else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    assign bus.gnt      = gnt_q;
    assign bus.gnt_id   = owner_q;
    assign bus.busy     = |gnt_q;
    assign bus.state    = state_q;
    assign bus.hold_cnt = hold_q;
`ifdef BUS_GRANT_TIMEOUT_EN
    assign bus.timeout  = timeout_q;
`else
    assign bus.timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_bus_grant_ctrl.sv
// Bench for bus_grant_ctrl: directed scenarios plus randomized requests,
// compared every cycle against a behavioural round-robin model.
// Optional feature macro: BUS_GRANT_TIMEOUT_EN.
module tb_bus_grant_ctrl;

    localparam int TB_MAX_HOLD = 4;
`ifdef BUS_GRANT_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_grant_ctrl_if bif ();

    bus_grant_ctrl #(.MAX_HOLD(TB_MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Packed expectation: [3:0] gnt, [5:4] gnt_id, [6] busy, [7] timeout, [15:8] hold
    logic [15:0] exp_q[$];

    int m_owner    = -1;  // current owner, -1 when the bus is free
    int m_released = -1;  // owner released/revoked last edge (turnaround cycle)
    int m_last     = 3;   // lowest-priority requester for the next pick
    int m_hold     = 0;
    int m_id       = 0;
    bit m_to       = 1'b0;

    function automatic int rr_first(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (last + k) % 4;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner    = -1;
        m_released = -1;
        m_last     = 3;
        m_hold     = 0;
        m_id       = 0;
        m_to       = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic [3:0] r);
        int w;
        m_to = 1'b0;
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_released = m_owner;
                m_owner    = -1;
                m_hold     = 0;
            end else if (TIMEOUT_ON && m_hold == TB_MAX_HOLD) begin
                m_to       = 1'b1;
                m_released = m_owner;
                m_owner    = -1;
                m_hold     = 0;
            end else if (m_hold < TB_MAX_HOLD) begin
                m_hold++;
            end
        end else begin
            if (m_released >= 0) begin
                m_last     = m_released;
                m_released = -1;
            end
            w = rr_first(r, m_last);
            if (w >= 0) begin
                m_owner = w;
                m_id    = w;
                m_hold  = 1;
            end
        end
    endtask

    function automatic logic [15:0] model_pack();
        logic [3:0] g;
        g = 4'b0000;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return {8'(m_hold), m_to, (m_owner >= 0), 2'(m_id), g};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_reset();
        end else begin
            model_step(bif.req);
            exp_q.push_back(model_pack());
        end
    end

    // ---------------- driver / per-cycle scoreboard ----------------
    task automatic tick();
        logic [15:0] e;
        @(negedge clk);
        if (!rst) begin
            check_eq("rst_gnt",     bif.gnt,      0);
            check_eq("rst_gnt_id",  bif.gnt_id,   0);
            check_eq("rst_busy",    bif.busy,     0);
            check_eq("rst_timeout", bif.timeout,  0);
            check_eq("rst_hold",    bif.hold_cnt, 0);
        end else begin
            check_eq("exp_q_depth", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("gnt",     bif.gnt,      e[3:0]);
                check_eq("gnt_id",  bif.gnt_id,   e[5:4]);
                check_eq("busy",    bif.busy,     e[6]);
                check_eq("timeout", bif.timeout,  e[7]);
                check_eq("hold",    bif.hold_cnt, e[15:8]);
            end
        end
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        bif.req = 4'b0000;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int e;
        int on_cnt;
        int to_cnt;
        int run;
        int max_run;
        logic [3:0] r;

        rst     = 1'b0;
        bif.req = 4'b0000;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_eq("idle_gnt", bif.gnt, 4'b0000);

        // single requester, one-cycle latency
        bif.req = 4'b0001;
        tick();
        check_eq("first_gnt",    bif.gnt,    4'b0001);
        check_eq("first_gnt_id", bif.gnt_id, 0);
        check_eq("first_busy",   bif.busy,   1);
        bif.req = 4'b0000;
        tick();
        check_eq("drop_gnt", bif.gnt, 4'b0000);
        tick();
        tick();
        check_eq("idle_gnt_id_held", bif.gnt_id, 0);

        // all requesting, each owner releases after 3 grant cycles
        do_reset();
        bif.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            e = k % 4;
            tick();
            check_eq("rr_order", bif.gnt, 32'(1) << e);
            tick();
            tick();
            check_eq("rr_hold", bif.gnt, 32'(1) << e);
            bif.req[e] = 1'b0;
            tick();
            check_eq("rr_turnaround", bif.gnt, 4'b0000);
            bif.req = 4'b1111;
        end

        // owner 2 not preempted, then hands over to 3
        do_reset();
        bif.req = 4'b0100;
        tick();
        bif.req = 4'b1111;
        tick();
        tick();
        check_eq("no_preempt", bif.gnt, 4'b0100);
        bif.req = 4'b1011;
        tick();
        check_eq("release_gap", bif.gnt, 4'b0000);
        tick();
        check_eq("next_after_2", bif.gnt, 4'b1000);

        // single long-holding requester: hold limit behaviour
        do_reset();
        bif.req = 4'b0010;
        on_cnt  = 0;
        to_cnt  = 0;
        run     = 0;
        max_run = 0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (bif.gnt[1]) begin
                on_cnt++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (bif.timeout) to_cnt++;
        end
        check_eq("hold_cycles", on_cnt,  TIMEOUT_ON ? 240 : 300);
        check_eq("timeouts",    to_cnt,  TIMEOUT_ON ? 60 : 0);
        check_eq("max_run",     max_run, TIMEOUT_ON ? TB_MAX_HOLD : 300);

        // asynchronous reset in the middle of a grant
        do_reset();
        bif.req = 4'b0100;
        tick();
        tick();
        check_eq("pre_async_gnt", bif.gnt, 4'b0100);
        #2 rst = 1'b0;
        #1;
        check_eq("async_gnt",  bif.gnt,  4'b0000);
        check_eq("async_busy", bif.busy, 0);
        tick();
        tick();
        rst     = 1'b1;
        bif.req = 4'b1010;
        tick();
        check_eq("post_rst_gnt", bif.gnt, 4'b0010);

        // randomized traffic
        r = 4'b0000;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 99) < 30) r = 4'($urandom_range(0, 15));
            bif.req = r;
            tick();
        end
        bif.req = 4'b0000;
        tick();
        tick();
        tick();
        check_eq("final_idle", bif.gnt, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_grant_ctrl.md
BUS_GRANT_CTRL -- requirements
Module: bus_grant_ctrl

Interface
REQ-001 Parameter: MAX_HOLD, 16, maximum consecutive grant cycles per ownership; legal range 2..255.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  4  request vector; req[i] high = requester i wants the shared bus.
REQ-005 Port: gnt  output  4  registered grant, one-hot or all-zero.
REQ-006 Port: gnt_id  output  2  encoded index of current owner; valid only while busy=1.
REQ-007 Port: busy  output  1  high while any gnt bit is high.
REQ-008 Port: timeout  output  1  one-cycle pulse when an ownership is revoked by the hold limit.

Function
REQ-009 The controller SHALL implement the FSM states IDLE, GRANT and RELEASE.
REQ-010 In IDLE with req!=0, it SHALL select the first asserted requester searching upward from (last_owner+1) mod 4, then enter GRANT with gnt asserted on the next edge (1-cycle latency).
REQ-011 In IDLE with req==0, it SHALL stay in IDLE with gnt=0 and last_owner unchanged.
REQ-012 In GRANT, gnt SHALL stay constant while the owner's req bit stays high; requests from other requesters SHALL NOT preempt it.
REQ-013 In GRANT, when the owner's req bit is sampled low, the FSM SHALL enter RELEASE and gnt SHALL be 0 from the following cycle.
REQ-014 RELEASE SHALL last exactly one cycle with gnt=0 (bus turnaround), update last_owner to the released index, then return to IDLE.
REQ-015 A requester granted and released SHALL get lowest priority in the next arbitration; with all four requesting continuously, grant order SHALL be 0,1,2,3,0,...
REQ-016 A hold counter SHALL count grant cycles from 1 and saturate at MAX_HOLD; it SHALL clear on entry to GRANT.
REQ-017 gnt_id SHALL equal the encoded gnt index; while busy=0 it SHALL hold its last value.
REQ-018 A req bit dropping and rising in the same RELEASE cycle SHALL be treated as a new request and arbitrated normally.

Reset
REQ-019 While rst=0: gnt=0, gnt_id=0, busy=0, timeout=0, hold counter=0, FSM=IDLE, last_owner=3 (requester 0 wins first).
REQ-020 Reset asserted mid-grant SHALL drop gnt asynchronously, without waiting for a clock edge.
REQ-021 After reset release, the first arbitration SHALL occur on the first rising edge with req!=0.

Configuration
REQ-022 Macro BUS_GRANT_TIMEOUT_EN: when defined, an ownership reaching MAX_HOLD cycles with req still high SHALL be revoked (GRANT->RELEASE), with timeout pulsed high for the one cycle RELEASE is entered.
REQ-023 Without BUS_GRANT_TIMEOUT_EN, ownership SHALL be unlimited, the timeout port SHALL remain present and tied 0, and the hold counter SHALL still count for debug.
REQ-024 A revoked requester SHALL be treated as released for priority purposes (REQ-015).

Structure
REQ-025 Package bus_ctrl_pkg SHALL hold the FSM state enum, NUM_REQ=4, the requester-index typedef (2 bits) and the MAX_HOLD default constant.
REQ-026 Combinational round-robin selection SHALL live in one sub-module, rr_pick (inputs req, last_owner; outputs valid, index); no other sub-modules.

Verification
REQ-027 Reset, then req=4'b0001 -> gnt=4'b0001 one cycle later, gnt_id=0, busy=1.
REQ-028 req=4'b1111 held continuously, owners release after 3 cycles each -> grant sequence 0,1,2,3,0 with exactly one gnt=0 cycle between grants.
REQ-029 Owner 2 holds, req=4'b1111; req[2] drops -> one RELEASE cycle, then gnt=4'b1000.
REQ-030 With BUS_GRANT_TIMEOUT_EN, MAX_HOLD=4, req[1] held high -> gnt[1] for 4 cycles, timeout=1 for one cycle, gnt=0, then re-grant to 1 if alone.
REQ-031 Without the macro, the same stimulus -> gnt[1] held indefinitely (checked for 300 cycles), timeout always 0.
REQ-032 rst pulled low mid-grant, between clock edges -> gnt=0 immediately; after release, req=4'b1010 -> gnt=4'b0010.
